// File: rtl/dca_matrix_mru_store.sv
// dca_matrix_mru_store
// Accepts blocked step instructions. A store step reads one matrix register,
// optionally transposes it, and queues the result in a small FIFO. The FIFO
// head is offered to LSU0 with a valid/ready handshake. A last-flagged step
// drains all outstanding work and then pulses done for one cycle.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous flush of all state
//   inst_valid/inst step instruction {last, opcode}
//   inst_ready      instruction accepted when inst_valid & inst_ready
//   mreg_rreq       matrix-register read strobe (same cycle as acceptance)
//   mreg_rdata      matrix read data, valid the cycle after mreg_rreq
//   lsu_wvalid/lsu_wdata/lsu_wready   store-data handshake toward LSU0
//   busy            instruction, read or FIFO entry outstanding
//   done            one-cycle pulse when a last-flagged sequence completes
//
// FSM states
//   ST_RUN   | accepting instructions
//   ST_DRAIN | last step accepted, waiting for reads and FIFO to empty
//   ST_FIN   | done pulse, return to ST_RUN next cycle
module dca_matrix_mru_store #(
    parameter int MATRIX_MAX_DIM                 = 4,
    parameter int BW_TENSOR_SCALAR               = 8,
    parameter int FIFO_DEPTH                     = 4,
    parameter int BW_DCA_MRU_OPCODE              = 4,
    parameter int DCA_MRU_OPCODE_INDEX_LSU0_REQ  = 0,
    parameter int DCA_MRU_OPCODE_INDEX_TRANSPOSE = 1,
    localparam int BW_TENSOR_MATRIX     = MATRIX_MAX_DIM * MATRIX_MAX_DIM * BW_TENSOR_SCALAR,
    localparam int BW_BLOCKED_STEP_INST = BW_DCA_MRU_OPCODE + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            inst_valid,
    input  logic [BW_BLOCKED_STEP_INST-1:0] inst,
    output logic                            inst_ready,
    output logic                            mreg_rreq,
    input  logic [BW_TENSOR_MATRIX-1:0]     mreg_rdata,
    output logic                            lsu_wvalid,
    output logic [BW_TENSOR_MATRIX-1:0]     lsu_wdata,
    input  logic                            lsu_wready,
    output logic                            busy,
    output logic                            done
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    state_t                      state_q;
    logic [CW-1:0]               count_q, count_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic                        inflight_q, inflight_d;
    logic                        tr_q, tr_d;
    logic [BW_TENSOR_MATRIX-1:0] mem_q [FIFO_DEPTH];
    logic [BW_TENSOR_MATRIX-1:0] push_data;

    logic inst_last;
    logic inst_store;
    logic inst_tr;
    logic inst_unused;
    logic space;
    logic accept;
    logic push;
    logic pop;

    assign inst_last   = inst[BW_DCA_MRU_OPCODE];
    assign inst_store  = inst[DCA_MRU_OPCODE_INDEX_LSU0_REQ];
    assign inst_tr     = inst[DCA_MRU_OPCODE_INDEX_TRANSPOSE];
    // Remaining opcode bits carry no meaning for this block.
    assign inst_unused = ^inst;

    // A read in flight already owns a FIFO slot, so it is counted as occupied.
    assign space = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < (CW + 1)'(FIFO_DEPTH);

    // Non-store steps need no FIFO slot, so they are not held off by a full FIFO.
    assign inst_ready = (state_q == ST_RUN) & ~clear & (space | (inst_valid & ~inst_store));
    assign accept     = inst_valid & inst_ready;
    assign mreg_rreq  = accept & inst_store;

    assign push = inflight_q;
    assign pop  = lsu_wvalid & lsu_wready;

    assign lsu_wvalid = (count_q != '0);
    assign lsu_wdata  = mem_q[rd_ptr_q];
    assign busy       = (state_q != ST_RUN) | inflight_q | (count_q != '0);
    assign done       = (state_q == ST_FIN);

    always_comb begin
        push_data = '0;
        for (int r = 0; r < MATRIX_MAX_DIM; r++) begin
            for (int c = 0; c < MATRIX_MAX_DIM; c++) begin
                if (tr_q) begin
                    push_data[(r*MATRIX_MAX_DIM+c+1)*BW_TENSOR_SCALAR-1 -: BW_TENSOR_SCALAR] =
                        mreg_rdata[(c*MATRIX_MAX_DIM+r+1)*BW_TENSOR_SCALAR-1 -: BW_TENSOR_SCALAR];
                end else begin
                    push_data[(r*MATRIX_MAX_DIM+c+1)*BW_TENSOR_SCALAR-1 -: BW_TENSOR_SCALAR] =
                        mreg_rdata[(r*MATRIX_MAX_DIM+c+1)*BW_TENSOR_SCALAR-1 -: BW_TENSOR_SCALAR];
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        inflight_d = mreg_rreq;
        tr_d       = mreg_rreq ? inst_tr : tr_q;
    end

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            tr_q       <= 1'b0;
        end else if (clear) begin
            state_q    <= ST_RUN;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            tr_q       <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            tr_q       <= tr_d;
            case (state_q)
                ST_RUN: begin
                    if (accept && inst_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                // Checks the registered occupancy, so the final pop is fully
                // retired before done is raised.
                ST_DRAIN: begin
                    if (count_q == '0 && !inflight_q) begin
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

endmodule
